// File: rtl/switch_port_pkt_if.sv
// Crossbar-side and consumer-side signal bundle for one switch output port.
// The slave modport is the port itself; master is the crossbar/consumer side.
interface switch_port_pkt_if #(
    parameter int unsigned W_WIDTH = 8,
    parameter int unsigned CNT_W   = 7
);
    logic               sw_en;
    logic [W_WIDTH-1:0] port_data;
    logic [W_WIDTH-1:0] port_addr;
    logic               rd_out;
    logic               port_rd;
    logic [W_WIDTH-1:0] port_out;
    logic               port_eop;
    logic               port_rdy;
    logic [CNT_W-1:0]   pkt_cnt;
    logic               pkt_drop;

    modport master (
        output sw_en, port_data, port_addr, port_rd,
        input  rd_out, port_out, port_eop, port_rdy, pkt_cnt, pkt_drop
    );

    modport slave (
        input  sw_en, port_data, port_addr, port_rd,
        output rd_out, port_out, port_eop, port_rdy, pkt_cnt, pkt_drop
    );
endinterface

// File: rtl/switch_port_pkt.sv
// Packet-aware switch output port: DA filter plus store-and-forward FIFO with whole-packet drop.
// Optional macro SWITCH_PORT_BCAST_EN: an all-ones DA is accepted in addition to port_addr.
module switch_port_pkt #(
    parameter int unsigned W_WIDTH   = 8,
    parameter int unsigned FIFO_SIZE = 64,
    parameter int unsigned CNT_W     = $clog2(FIFO_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    switch_port_pkt_if.slave     sp
);
    localparam int unsigned AW = $clog2(FIFO_SIZE);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {IDLE, RECV, SKIP, DROP} state_t;

    state_t             r_state, w_state_nxt;
    logic [PW-1:0]      r_wr_ptr, r_cmt_ptr, r_rd_ptr;
    logic [W_WIDTH-1:0] r_stg_data;
    logic               r_stg_vld;
    logic [CNT_W-1:0]   r_pkt_cnt;
    logic               r_drop;
    logic [W_WIDTH:0]   r_mem [FIFO_SIZE];

    logic [PW-1:0]      w_used;
    logic               w_full;
    logic               w_match;
    logic               w_wr, w_wr_eop, w_drop, w_commit, w_stg_load, w_stg_clr;
    logic               w_rdy, w_pop, w_pop_eop;
    logic [W_WIDTH:0]   w_head;

    assign w_used = r_wr_ptr - r_rd_ptr;
    assign w_full = (w_used == PW'(FIFO_SIZE));

`ifdef SWITCH_PORT_BCAST_EN
    assign w_match = (sp.port_data == sp.port_addr) || (sp.port_data == '1);
`else
    assign w_match = (sp.port_data == sp.port_addr);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // The staged word is only written once we know whether it is the last one,
    // so a write is needed whenever stg holds data and another word or frame end arrives.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_wr_eop    = 1'b0;
        w_drop      = 1'b0;
        w_commit    = 1'b0;
        w_stg_load  = 1'b0;
        w_stg_clr   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (sp.sw_en) w_state_nxt = w_match ? RECV : SKIP;
            end
            RECV: begin
                if (sp.sw_en) begin
                    if (r_stg_vld && w_full) begin
                        w_drop      = 1'b1;
                        w_stg_clr   = 1'b1;
                        w_state_nxt = DROP;
                    end else begin
                        w_stg_load = 1'b1;
                        w_wr       = r_stg_vld;
                    end
                end else begin
                    w_stg_clr   = 1'b1;
                    w_state_nxt = IDLE;
                    if (r_stg_vld) begin
                        if (w_full) begin
                            w_drop = 1'b1;
                        end else begin
                            w_wr     = 1'b1;
                            w_wr_eop = 1'b1;
                            w_commit = 1'b1;
                        end
                    end
                end
            end
            SKIP, DROP: begin
                if (!sp.sw_en) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_cmt_ptr  <= '0;
            r_stg_data <= '0;
            r_stg_vld  <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_drop <= w_drop;
            if (w_drop)    r_wr_ptr <= r_cmt_ptr;
            else if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_commit)  r_cmt_ptr <= r_wr_ptr + PW'(1);
            if (w_stg_clr) begin
                r_stg_vld <= 1'b0;
            end else if (w_stg_load) begin
                r_stg_data <= sp.port_data;
                r_stg_vld  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= {w_wr_eop, r_stg_data};
    end

    assign w_rdy     = (r_pkt_cnt != '0);
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_pop     = sp.port_rd && w_rdy;
    assign w_pop_eop = w_pop && w_head[W_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr  <= '0;
            r_pkt_cnt <= '0;
        end else begin
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            unique case ({w_commit, w_pop_eop})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
                2'b01:   r_pkt_cnt <= r_pkt_cnt - CNT_W'(1);
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

    assign sp.rd_out   = (PW'(FIFO_SIZE) - w_used) >= PW'(2);
    assign sp.port_out = w_rdy ? w_head[W_WIDTH-1:0] : '0;
    assign sp.port_eop = w_rdy ? w_head[W_WIDTH] : 1'b0;
    assign sp.port_rdy = w_rdy;
    assign sp.pkt_cnt  = r_pkt_cnt;
    assign sp.pkt_drop = r_drop;
endmodule
